// File: rtl/rename_regfile_pkg.sv
// Shared definitions for the renaming register file: default sizes,
// the {busy, tag} map entry, a clog2 helper and the hard-wired-zero index.
package rename_regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREG_DEF  = 32;
  localparam int unsigned TAG_W_DEF = 4;
  localparam int unsigned NRD_DEF   = 2;
  localparam int unsigned NCKPT_DEF = 4;
  localparam int unsigned REG_ZERO  = 0;

  // Index width for n entries, never below one bit
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    for (w = 1; (32'd1 << w) < n; w++) begin
    end
    return w;
  endfunction

  localparam int unsigned RW_DEF = clog2(NREG_DEF);

  // One rename-map entry: busy means the value is still owed by ROB tag
  typedef struct packed {
    logic                 busy;
    logic [TAG_W_DEF-1:0] tag;
  } map_ent_t;

endpackage

// File: rtl/rename_ckpt_bank.sv
// Branch checkpoint storage for the rename map: NCKPT snapshots of
// busy/tag, a valid bitmap, lowest-free allocator and the commit-clear
// broadcast that keeps snapshots from waiting on retired tags.
import rename_regfile_pkg::*;

module rename_ckpt_bank #(
  parameter int unsigned NREG  = NREG_DEF,
  parameter int unsigned TAG_W = TAG_W_DEF,
  parameter int unsigned NCKPT = NCKPT_DEF,
  localparam int unsigned RW   = clog2(NREG),
  localparam int unsigned CW   = clog2(NCKPT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  clear_i,
  input  logic                  save_i,
  input  logic                  restore_i,
  input  logic [CW-1:0]         restore_id_i,
  input  logic [NCKPT-1:0]      kill_mask_i,
  input  logic                  free_i,
  input  logic [CW-1:0]         free_id_i,
  input  logic [NREG-1:0]       snap_busy_i,
  input  logic [NREG*TAG_W-1:0] snap_tag_i,
  input  logic                  commit_hit_i,
  input  logic [RW-1:0]         commit_reg_i,
  input  logic [TAG_W-1:0]      commit_tag_i,
  output logic [CW-1:0]         alloc_id_c_o,
  output logic                  avail_c_o,
  output logic [NREG-1:0]       rest_busy_c_o,
  output logic [NREG*TAG_W-1:0] rest_tag_c_o
);

  logic [NREG-1:0]       busy_q [NCKPT];
  logic [NREG-1:0]       busy_d [NCKPT];
  logic [NREG*TAG_W-1:0] tag_q  [NCKPT];
  logic [NREG*TAG_W-1:0] tag_d  [NCKPT];
  logic [NCKPT-1:0]      valid_q;
  logic [NCKPT-1:0]      valid_d;

  // Lowest-index free checkpoint
  always_comb begin
    alloc_id_c_o = '0;
    for (int c = int'(NCKPT) - 1; c >= 0; c--) begin
      if (!valid_q[c]) alloc_id_c_o = CW'(c);
    end
    avail_c_o = ~&valid_q;
  end

  // Restored map with the same-cycle commit clear applied on top
  always_comb begin
    rest_tag_c_o = tag_q[restore_id_i];
    for (int unsigned r = 0; r < NREG; r++) begin
      rest_busy_c_o[r] = busy_q[restore_id_i][r] &
                         ~(commit_hit_i && (commit_reg_i == RW'(r)) &&
                           (rest_tag_c_o[r*TAG_W +: TAG_W] == commit_tag_i));
    end
  end

  // Next state: commit broadcast, invalidation, then save (save wins over free)
  always_comb begin
    busy_d  = busy_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    for (int unsigned c = 0; c < NCKPT; c++) begin
      if (valid_q[c] && commit_hit_i &&
          (tag_q[c][commit_reg_i*TAG_W +: TAG_W] == commit_tag_i)) begin
        busy_d[c][commit_reg_i] = 1'b0;
      end
    end
    if (clear_i) begin
      valid_d = '0;
    end else begin
      if (restore_i) valid_d = valid_d & ~kill_mask_i;
      if (free_i) valid_d[free_id_i] = 1'b0;
      if (save_i && !restore_i && avail_c_o) begin
        busy_d[alloc_id_c_o]  = snap_busy_i;
        tag_d[alloc_id_c_o]   = snap_tag_i;
        valid_d[alloc_id_c_o] = 1'b1;
      end
    end
  end

  // Checkpoint state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '{default: '0};
      tag_q   <= '{default: '0};
      valid_q <= '0;
    end else if (en_i) begin
      busy_q  <= busy_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with ROB-tag renaming, combinational read
// ports with commit bypass, one commit per cycle.
// Optional branch checkpoints of the rename map: RENAME_CKPT_EN.
import rename_regfile_pkg::*;

module rename_regfile #(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREG  = NREG_DEF,
  parameter int unsigned TAG_W = TAG_W_DEF,
  parameter int unsigned NRD   = NRD_DEF,
  parameter int unsigned NCKPT = NCKPT_DEF,
  localparam int unsigned RW   = clog2(NREG),
  localparam int unsigned CW   = clog2(NCKPT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     issue_sig,
  input  logic [RW-1:0]            issue_rd,
  input  logic [TAG_W-1:0]         issue_rob_tag,
  input  logic [NRD*RW-1:0]        rd_reg,
  output logic [NRD*XLEN-1:0]      rd_val,
  output logic [NRD*(TAG_W+1)-1:0] rd_tag,
  input  logic                     commit_sig,
  input  logic [RW-1:0]            commit_reg,
  input  logic [XLEN-1:0]          commit_val,
  input  logic [TAG_W-1:0]         commit_rob_tag,
  input  logic                     clear,
  input  logic                     ckpt_save,
  output logic [CW-1:0]            ckpt_alloc_id,
  output logic                     ckpt_avail,
  input  logic                     ckpt_restore,
  input  logic [CW-1:0]            ckpt_restore_id,
  input  logic                     ckpt_free,
  input  logic [CW-1:0]            ckpt_free_id,
  input  logic [NCKPT-1:0]         ckpt_kill_mask
);

  logic [XLEN-1:0]       val_q [NREG];
  logic [XLEN-1:0]       val_d [NREG];
  logic [NREG-1:0]       busy_q;
  logic [NREG-1:0]       busy_d;
  logic [TAG_W-1:0]      tag_q [NREG];
  logic [TAG_W-1:0]      tag_d [NREG];
  logic                  commit_hit;
  logic                  issue_hit;
  logic [NREG-1:0]       pc_busy;
  logic                  restore_en;
  logic [NREG-1:0]       rest_busy;
  logic [NREG*TAG_W-1:0] rest_tag;

  assign commit_hit = rdy && commit_sig && (commit_reg != RW'(REG_ZERO));
  assign issue_hit  = issue_sig && (issue_rd != RW'(REG_ZERO));

  // Live map after this cycle's commit clear, before issue
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      pc_busy[r] = busy_q[r] & ~(commit_hit && (commit_reg == RW'(r)) &&
                                 (tag_q[r] == commit_rob_tag));
    end
  end

`ifdef RENAME_CKPT_EN
  logic [NREG*TAG_W-1:0] snap_tag;

  // Flatten the live tags for snapshotting
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) snap_tag[r*TAG_W +: TAG_W] = tag_q[r];
  end

  assign restore_en = ckpt_restore;

  rename_ckpt_bank #(
    .NREG (NREG),
    .TAG_W(TAG_W),
    .NCKPT(NCKPT)
  ) u_ckpt (
    .clk          (clk),
    .rst          (rst),
    .en_i         (rdy),
    .clear_i      (clear),
    .save_i       (ckpt_save),
    .restore_i    (ckpt_restore),
    .restore_id_i (ckpt_restore_id),
    .kill_mask_i  (ckpt_kill_mask),
    .free_i       (ckpt_free),
    .free_id_i    (ckpt_free_id),
    .snap_busy_i  (pc_busy),
    .snap_tag_i   (snap_tag),
    .commit_hit_i (commit_hit),
    .commit_reg_i (commit_reg),
    .commit_tag_i (commit_rob_tag),
    .alloc_id_c_o (ckpt_alloc_id),
    .avail_c_o    (ckpt_avail),
    .rest_busy_c_o(rest_busy),
    .rest_tag_c_o (rest_tag)
  );
`else
  logic ckpt_unused;

  assign ckpt_unused   = ^{ckpt_save, ckpt_restore, ckpt_restore_id,
                           ckpt_free, ckpt_free_id, ckpt_kill_mask};
  assign restore_en    = 1'b0;
  assign rest_busy     = '0;
  assign rest_tag      = '0;
  assign ckpt_alloc_id = '0;
  assign ckpt_avail    = 1'b0;
`endif

  // Next state: values always take the commit; map priority clear > restore > issue/commit
  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (commit_hit) val_d[commit_reg] = commit_val;
    if (clear) begin
      busy_d = '0;
    end else if (restore_en) begin
      busy_d = rest_busy;
      for (int unsigned r = 0; r < NREG; r++) tag_d[r] = rest_tag[r*TAG_W +: TAG_W];
    end else begin
      busy_d = pc_busy;
      if (issue_hit) begin
        busy_d[issue_rd] = 1'b1;
        tag_d[issue_rd]  = issue_rob_tag;
      end
    end
  end

  // Live state registers; rdy low freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q  <= '{default: '0};
      busy_q <= '0;
      tag_q  <= '{default: '0};
    end else if (rdy) begin
      val_q  <= val_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  // Read ports with commit bypass; x0 and reset read as zero
  always_comb begin
    logic [RW-1:0] idx;
    for (int unsigned k = 0; k < NRD; k++) begin
      idx = rd_reg[k*RW +: RW];
      rd_val[k*XLEN +: XLEN]           = '0;
      rd_tag[k*(TAG_W+1) +: (TAG_W+1)] = '0;
      if (!rst && (idx != RW'(REG_ZERO))) begin
        if (commit_hit && (commit_reg == idx) && (tag_q[idx] == commit_rob_tag)) begin
          rd_val[k*XLEN +: XLEN]           = commit_val;
          rd_tag[k*(TAG_W+1) +: (TAG_W+1)] = {1'b0, tag_q[idx]};
        end else begin
          rd_val[k*XLEN +: XLEN]           = val_q[idx];
          rd_tag[k*(TAG_W+1) +: (TAG_W+1)] = {busy_q[idx], tag_q[idx]};
        end
      end
    end
  end

endmodule

// File: tb/tb_rename_regfile.sv
// Directed self-checking bench for rename_regfile (4 checkpoints, 2 read ports).
module tb_rename_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        issue_sig;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_rob_tag;
  logic [9:0]  rd_reg;
  logic [63:0] rd_val;
  logic [9:0]  rd_tag;
  logic        commit_sig;
  logic [4:0]  commit_reg;
  logic [31:0] commit_val;
  logic [3:0]  commit_rob_tag;
  logic        clear;
  logic        ckpt_save;
  logic [1:0]  ckpt_alloc_id;
  logic        ckpt_avail;
  logic        ckpt_restore;
  logic [1:0]  ckpt_restore_id;
  logic        ckpt_free;
  logic [1:0]  ckpt_free_id;
  logic [3:0]  ckpt_kill_mask;

  int n_vec = 0;
  int n_bad = 0;

  rename_regfile #(
    .XLEN(32), .NREG(32), .TAG_W(4), .NRD(2), .NCKPT(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .issue_sig      (issue_sig),
    .issue_rd       (issue_rd),
    .issue_rob_tag  (issue_rob_tag),
    .rd_reg         (rd_reg),
    .rd_val         (rd_val),
    .rd_tag         (rd_tag),
    .commit_sig     (commit_sig),
    .commit_reg     (commit_reg),
    .commit_val     (commit_val),
    .commit_rob_tag (commit_rob_tag),
    .clear          (clear),
    .ckpt_save      (ckpt_save),
    .ckpt_alloc_id  (ckpt_alloc_id),
    .ckpt_avail     (ckpt_avail),
    .ckpt_restore   (ckpt_restore),
    .ckpt_restore_id(ckpt_restore_id),
    .ckpt_free      (ckpt_free),
    .ckpt_free_id   (ckpt_free_id),
    .ckpt_kill_mask (ckpt_kill_mask)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_sig = 0; issue_rd = 0; issue_rob_tag = 0;
    commit_sig = 0; commit_reg = 0; commit_val = 0; commit_rob_tag = 0;
    clear = 0; ckpt_save = 0; ckpt_restore = 0; ckpt_restore_id = 0;
    ckpt_free = 0; ckpt_free_id = 0; ckpt_kill_mask = 0;
  endtask

  task automatic do_issue(input logic [4:0] r, input logic [3:0] t);
    issue_sig = 1; issue_rd = r; issue_rob_tag = t;
  endtask

  task automatic do_commit(input logic [4:0] r, input logic [3:0] t, input logic [31:0] v);
    commit_sig = 1; commit_reg = r; commit_rob_tag = t; commit_val = v;
  endtask

  task automatic test_reset();
    rst = 1; rdy = 1; idle(); rd_reg = {5'd6, 5'd5};
    tick(); tick();
    n_vec++;
    if (rd_val !== 64'h0 || rd_tag !== 10'h0) begin
      n_bad++; $display("FAIL reset_reads got val=%h tag=%h want 0/0", rd_val, rd_tag);
    end
`ifdef RENAME_CKPT_EN
    n_vec++;
    if (ckpt_avail !== 1'b1 || ckpt_alloc_id !== 2'd0) begin
      n_bad++; $display("FAIL reset_ckpt got avail=%b id=%0d want 1/0", ckpt_avail, ckpt_alloc_id);
    end
`else
    n_vec++;
    if (ckpt_avail !== 1'b0 || ckpt_alloc_id !== 2'd0) begin
      n_bad++; $display("FAIL reset_ckpt_off got avail=%b id=%0d want 0/0", ckpt_avail, ckpt_alloc_id);
    end
`endif
    rst = 0;
  endtask

  task automatic test_issue_commit();
    do_issue(5'd5, 4'd3); rd_reg = {5'd0, 5'd5};
    tick(); idle(); #1;
    n_vec++;
    if (rd_tag[4:0] !== 5'h13) begin
      n_bad++; $display("FAIL issue_busy got %h want %h", rd_tag[4:0], 5'h13);
    end
    do_commit(5'd5, 4'd3, 32'hDEAD); #1;
    n_vec++;
    if (rd_val[31:0] !== 32'hDEAD || rd_tag[4] !== 1'b0) begin
      n_bad++; $display("FAIL commit_bypass got val=%h busy=%b want DEAD/0", rd_val[31:0], rd_tag[4]);
    end
    tick(); idle(); #1;
    n_vec++;
    if (rd_val[31:0] !== 32'hDEAD || rd_tag[4:0] !== 5'h03) begin
      n_bad++; $display("FAIL commit_stored got val=%h tag=%h want DEAD/03", rd_val[31:0], rd_tag[4:0]);
    end
  endtask

  task automatic test_tag_order();
    do_issue(5'd7, 4'd2); tick();
    do_issue(5'd7, 4'd9); tick();
    idle(); do_commit(5'd7, 4'd2, 32'h77); rd_reg = {5'd0, 5'd7}; #1;
    n_vec++;
    if (rd_val[31:0] !== 32'h0 || rd_tag[4:0] !== 5'h19) begin
      n_bad++; $display("FAIL stale_commit_read got val=%h tag=%h want 0/19", rd_val[31:0], rd_tag[4:0]);
    end
    tick(); idle(); #1;
    n_vec++;
    if (rd_val[31:0] !== 32'h77 || rd_tag[4:0] !== 5'h19) begin
      n_bad++; $display("FAIL stale_commit_keep got val=%h tag=%h want 77/19", rd_val[31:0], rd_tag[4:0]);
    end
    do_issue(5'd7, 4'd4); do_commit(5'd7, 4'd9, 32'h99); #1;
    n_vec++;
    if (rd_val[31:0] !== 32'h99 || rd_tag[4:0] !== 5'h09) begin
      n_bad++; $display("FAIL issue_commit_same_read got val=%h tag=%h want 99/09", rd_val[31:0], rd_tag[4:0]);
    end
    tick(); idle(); #1;
    n_vec++;
    if (rd_val[31:0] !== 32'h99 || rd_tag[4:0] !== 5'h14) begin
      n_bad++; $display("FAIL issue_beats_commit got val=%h tag=%h want 99/14", rd_val[31:0], rd_tag[4:0]);
    end
  endtask

  task automatic test_rdy_hold();
    rdy = 0; do_commit(5'd7, 4'd4, 32'hFFFF); do_issue(5'd9, 4'd5);
    rd_reg = {5'd9, 5'd7}; #1;
    n_vec++;
    if (rd_val[31:0] !== 32'h99 || rd_tag[4:0] !== 5'h14) begin
      n_bad++; $display("FAIL rdy_low_read got val=%h tag=%h want 99/14", rd_val[31:0], rd_tag[4:0]);
    end
    tick(); #1;
    n_vec++;
    if (rd_val !== {32'h0, 32'h99} || rd_tag !== {5'h00, 5'h14}) begin
      n_bad++; $display("FAIL rdy_low_hold got val=%h tag=%h want 0_99/00_14", rd_val, rd_tag);
    end
    idle(); rdy = 1;
  endtask

  task automatic test_x0();
    do_issue(5'd0, 4'd3); do_commit(5'd0, 4'd3, 32'hFFFF); rd_reg = {5'd0, 5'd0}; #1;
    n_vec++;
    if (rd_val !== 64'h0 || rd_tag !== 10'h0) begin
      n_bad++; $display("FAIL x0_same_cycle got val=%h tag=%h want 0/0", rd_val, rd_tag);
    end
    tick(); idle(); #1;
    n_vec++;
    if (rd_val !== 64'h0 || rd_tag !== 10'h0) begin
      n_bad++; $display("FAIL x0_after got val=%h tag=%h want 0/0", rd_val, rd_tag);
    end
  endtask

`ifdef RENAME_CKPT_EN
  task automatic test_ckpt_restore();
    do_issue(5'd1, 4'd1); tick(); idle();
    ckpt_save = 1; #1;
    n_vec++;
    if (ckpt_alloc_id !== 2'd0 || ckpt_avail !== 1'b1) begin
      n_bad++; $display("FAIL save_alloc got id=%0d avail=%b want 0/1", ckpt_alloc_id, ckpt_avail);
    end
    tick(); idle(); #1;
    n_vec++;
    if (ckpt_alloc_id !== 2'd1 || ckpt_avail !== 1'b1) begin
      n_bad++; $display("FAIL after_save got id=%0d avail=%b want 1/1", ckpt_alloc_id, ckpt_avail);
    end
    do_issue(5'd1, 4'd5); tick(); idle();
    do_commit(5'd1, 4'd1, 32'hAB); rd_reg = {5'd0, 5'd1}; tick(); idle(); #1;
    n_vec++;
    if (rd_val[31:0] !== 32'hAB || rd_tag[4:0] !== 5'h15) begin
      n_bad++; $display("FAIL pre_restore got val=%h tag=%h want AB/15", rd_val[31:0], rd_tag[4:0]);
    end
    ckpt_restore = 1; ckpt_restore_id = 2'd0; ckpt_kill_mask = 4'b0001;
    tick(); idle(); #1;
    n_vec++;
    if (rd_val[31:0] !== 32'hAB || rd_tag[4:0] !== 5'h01) begin
      n_bad++; $display("FAIL restore_map got val=%h tag=%h want AB/01", rd_val[31:0], rd_tag[4:0]);
    end
    n_vec++;
    if (ckpt_alloc_id !== 2'd0 || ckpt_avail !== 1'b1) begin
      n_bad++; $display("FAIL restore_kill got id=%0d avail=%b want 0/1", ckpt_alloc_id, ckpt_avail);
    end
  endtask

  task automatic test_ckpt_full();
    logic [1:0] exp_id;
    for (int i = 0; i < 4; i++) begin
      ckpt_save = 1; tick(); idle(); #1;
      exp_id = 2'(i + 1);
      n_vec++;
      if (i < 3 && (ckpt_alloc_id !== exp_id || ckpt_avail !== 1'b1)) begin
        n_bad++; $display("FAIL fill_%0d got id=%0d avail=%b want %0d/1", i, ckpt_alloc_id, ckpt_avail, exp_id);
      end else if (i == 3 && ckpt_avail !== 1'b0) begin
        n_bad++; $display("FAIL fill_full got avail=%b want 0", ckpt_avail);
      end
    end
    ckpt_save = 1; tick(); idle();
    ckpt_free = 1; ckpt_free_id = 2'd2; tick(); idle(); #1;
    n_vec++;
    if (ckpt_alloc_id !== 2'd2 || ckpt_avail !== 1'b1) begin
      n_bad++; $display("FAIL free_id2 got id=%0d avail=%b want 2/1", ckpt_alloc_id, ckpt_avail);
    end
    ckpt_free = 1; ckpt_free_id = 2'd2; ckpt_save = 1; tick(); idle(); #1;
    n_vec++;
    if (ckpt_avail !== 1'b0) begin
      n_bad++; $display("FAIL save_beats_free got avail=%b want 0", ckpt_avail);
    end
  endtask
`else
  task automatic test_ckpt_disabled();
    do_issue(5'd1, 4'd5); ckpt_save = 1; ckpt_restore = 1; ckpt_restore_id = 2'd0;
    ckpt_kill_mask = 4'b1111; rd_reg = {5'd0, 5'd1};
    tick(); idle(); #1;
    n_vec++;
    if (rd_tag[4:0] !== 5'h15 || ckpt_avail !== 1'b0 || ckpt_alloc_id !== 2'd0) begin
      n_bad++; $display("FAIL ckpt_ignored got tag=%h avail=%b id=%0d want 15/0/0", rd_tag[4:0], ckpt_avail, ckpt_alloc_id);
    end
  endtask
`endif

  task automatic test_clear();
    do_issue(5'd3, 4'd1); tick(); idle();
    do_issue(5'd8, 4'd2); tick(); idle();
    clear = 1; do_commit(5'd3, 4'd0, 32'h11); do_issue(5'd4, 4'd5);
    tick(); idle();
    rd_reg = {5'd8, 5'd3}; #1;
    n_vec++;
    if (rd_val[31:0] !== 32'h11 || rd_tag !== {5'h02, 5'h01}) begin
      n_bad++; $display("FAIL clear_x3_x8 got val=%h tag=%h want 11/02_01", rd_val[31:0], rd_tag);
    end
    rd_reg = {5'd7, 5'd4}; #1;
    n_vec++;
    if (rd_tag !== {5'h04, 5'h00}) begin
      n_bad++; $display("FAIL clear_x4_x7 got tag=%h want 04_00", rd_tag);
    end
`ifdef RENAME_CKPT_EN
    n_vec++;
    if (ckpt_avail !== 1'b1 || ckpt_alloc_id !== 2'd0) begin
      n_bad++; $display("FAIL clear_ckpt got avail=%b id=%0d want 1/0", ckpt_avail, ckpt_alloc_id);
    end
`endif
  endtask

  task automatic test_reset_mid();
    rst = 1; rd_reg = {5'd5, 5'd3}; #1;
    n_vec++;
    if (rd_val !== 64'h0 || rd_tag !== 10'h0) begin
      n_bad++; $display("FAIL rst_gates_reads got val=%h tag=%h want 0/0", rd_val, rd_tag);
    end
    tick(); rst = 0; #1;
    n_vec++;
    if (rd_val !== 64'h0 || rd_tag !== 10'h0) begin
      n_bad++; $display("FAIL rst_clears_state got val=%h tag=%h want 0/0", rd_val, rd_tag);
    end
  endtask

  initial begin
    test_reset();
    test_issue_commit();
    test_tag_order();
    test_rdy_hold();
    test_x0();
`ifdef RENAME_CKPT_EN
    test_ckpt_restore();
    test_ckpt_full();
`else
    test_ckpt_disabled();
`endif
    test_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
- Parametrised successor of the architectural register file with ROB-tag renaming.
- Holds XLEN-bit architectural values plus a per-register busy bit and ROB tag.
- Serves NRD combinational read ports to the dispatcher and accepts one ROB commit per cycle.
- Adds branch checkpoints of the rename map, so a mispredict restores the tags instead of clearing all busy bits.

Parameters:
- XLEN, 32, register data width
- NREG, 32, architectural register count (index width RW = clog2(NREG)); register 0 is hard-wired zero
- TAG_W, 4, ROB tag width
- NRD, 2, number of read ports
- NCKPT, 4, number of rename-map checkpoints (index width CW = clog2(NCKPT))

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; when low, all state holds and all inputs are ignored
- issue_sig  in  1  dispatcher allocates a destination this cycle
- issue_rd  in  RW  destination register
- issue_rob_tag  in  TAG_W  ROB tag assigned to the destination
- rd_reg  in  NRD*RW  read register indices, port k at slice k
- rd_val  out  NRD*XLEN  read values
- rd_tag  out  NRD*(TAG_W+1)  per port {busy, tag}; busy=1 means wait for the tag
- commit_sig  in  1  ROB commit valid
- commit_reg  in  RW  committed register
- commit_val  in  XLEN  committed value
- commit_rob_tag  in  TAG_W  committed ROB tag
- clear  in  1  full pipeline flush
- ckpt_save  in  1  take a snapshot (branch dispatch)
- ckpt_alloc_id  out  CW  id that a save this cycle will use
- ckpt_avail  out  1  at least one free checkpoint
- ckpt_restore  in  1  mispredict recovery
- ckpt_restore_id  in  CW  checkpoint to restore
- ckpt_free  in  1  release a checkpoint (branch resolved correct)
- ckpt_free_id  in  CW  checkpoint to release
- ckpt_kill_mask  in  NCKPT  checkpoints invalidated by the restore (younger branches plus the restored one)

Behaviour:
- Reset: all values 0, busy 0, tags 0, all checkpoints invalid. ckpt_avail=1, ckpt_alloc_id=0. Read outputs are 0 while rst is high.
- Commit (commit_sig, commit_reg!=0):
  - The value is written next edge, regardless of clear or restore.
  - The live busy bit clears if the stored tag equals commit_rob_tag and there is no same-cycle issue to the same register.
  - The same tag-match clear is applied to every valid checkpoint entry for commit_reg. This keeps restored maps from waiting on retired tags.
- Issue (issue_sig, issue_rd!=0): busy<=1, tag<=issue_rob_tag. Issue beats a same-cycle commit clear on the same register.
- Reads are combinational, zero latency:
  - If commit hits (commit_sig, reg!=0, reg==rd_reg, tag matches): val=commit_val, busy=0.
  - Otherwise the stored value and {busy, tag}.
  - Register 0 always reads val 0, busy 0.
  - Reads do not see same-cycle issue.
- Save: writes the snapshot to ckpt_alloc_id and marks it valid. The snapshot is the post-commit, pre-issue live map. Save while !ckpt_avail is ignored; the dispatcher must stall.
- Allocation: ckpt_alloc_id is the lowest-index invalid checkpoint; ckpt_avail = |~valid. Both are registered-state combinational.
- Restore:
  - Live busy/tag <= checkpoint[ckpt_restore_id], with the same-cycle commit clear applied on top.
  - Same-cycle issue and save are ignored.
  - Checkpoints in ckpt_kill_mask become invalid.
- Free: invalidates ckpt_free_id. Free of an invalid id is a no-op. Free and save of the same id in one cycle: save wins.
- Priority for busy/tag state: rst > clear > restore > issue/commit. Clear zeros all live busy bits and invalidates all checkpoints; value writes from commit still happen.
- rdy low: no state changes; read outputs stay driven from current state.

Optional Feature:
- Macro RENAME_CKPT_EN.
- Defined: checkpoint logic as above.
- Undefined:
  - No checkpoint storage.
  - ckpt_avail ties to 0 and ckpt_alloc_id to 0.
  - ckpt_save, ckpt_restore and ckpt_free are ignored.
  - Recovery relies on clear only, as in the previous generation.

Decomposition:
- Shared package: XLEN/TAG_W/RW defaults, the {busy, tag} entry struct, a clog2 helper, and the reg-0 constant.
- One sub-module, rename_ckpt_bank: the NCKPT x NREG busy/tag storage, valid bitmap, allocator and commit-clear broadcast. The top keeps values, the live map and the read ports.

Test Plan:
- After reset, issue x5 tag 3; next cycle read x5 -> busy=1 tag=3. Commit x5 tag 3 val 0xDEAD -> same-cycle read val 0xDEAD busy=0; next cycle stored value 0xDEAD, busy=0.
- Issue x7 tag 2, then x7 tag 9; commit x7 tag 2 -> value written, busy stays 1 tag 9. Same-cycle issue x7 tag 4 with commit x7 tag 9 -> busy=1 tag=4.
- Issue x1 tag 1. Save (id 0, ckpt_avail stays 1). Issue x1 tag 5. Commit tag 1. Restore id 0 with mask 0001 -> x1 busy=0 (commit propagated into the checkpoint); ckpt_alloc_id returns to 0.
- Save NCKPT times -> ckpt_avail=0; extra save ignored. Free id 2 -> ckpt_alloc_id=2, ckpt_avail=1.
- Clear with simultaneous commit x3 val 0x11 and issue x4 -> all busy=0, all checkpoints invalid, x3 reads 0x11, x4 not busy.
- Issue or commit to x0 with val 0xFFFF -> reads x0 val 0, busy 0. Same stimulus with rdy=0 -> no state change.
